// File: rtl/sat_accum_neuron_if.sv
// Streaming handshake bundle for sat_accum_neuron: input beat channel and result channel.
interface sat_accum_neuron_if #(
    parameter int DATA_W = 8
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/sat_accum_neuron.sv
// Accumulates up to N_IN signed beats plus a bias, then emits a saturated (optionally
// ReLU-clipped) DATA_W-bit result held until the consumer takes it.
module sat_accum_neuron #(
    parameter int DATA_W = 8,
    parameter int N_IN   = 8,
    parameter int ACC_W  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     relu_en,
    sat_accum_neuron_if.slave        io,
    output logic                     busy
);
    localparam int CNT_W = $clog2(N_IN + 1);
    localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MIN_S = ~MAX_S;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [DATA_W-1:0]  out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;

    logic                      accept;
    logic                      is_final;
    logic signed [ACC_W-1:0]   acc_base;
    logic signed [ACC_W-1:0]   sum;
    logic        [CNT_W-1:0]   cnt_inc;
    logic        [DATA_W:0]    result;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] x);
        return {{(ACC_W - DATA_W){x[DATA_W-1]}}, x};
    endfunction

    // Returns {sat_flag, data}; ReLU is applied after clamping and clears the flag.
    function automatic logic [DATA_W:0] sat_relu(input logic signed [ACC_W-1:0] s,
                                                 input logic relu);
        logic [DATA_W-1:0] d;
        logic              f;
        if (s > MAX_S) begin
            d = {1'b0, {(DATA_W - 1){1'b1}}};
            f = 1'b1;
        end else if (s < MIN_S) begin
            d = {1'b1, {(DATA_W - 1){1'b0}}};
            f = 1'b1;
        end else begin
            d = s[DATA_W-1:0];
            f = 1'b0;
        end
        if (relu && d[DATA_W-1]) begin
            d = '0;
            f = 1'b0;
        end
        return {f, d};
    endfunction

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;

        accept   = io.in_valid && (state_q != HOLD);
        acc_base = (state_q == IDLE) ? sext(bias) : acc_q;
        sum      = acc_base + sext(io.in_data);
        cnt_inc  = ((state_q == IDLE) ? CNT_W'(0) : cnt_q) + CNT_W'(1);
        is_final = io.in_last || (cnt_inc == CNT_W'(N_IN));
        result   = sat_relu(sum, relu_en);

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
                    if (is_final) begin
                        state_d    = HOLD;
                        out_sat_d  = result[DATA_W];
                        out_data_d = result[DATA_W-1:0];
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            HOLD: begin
                // Result consumed: clear the working registers for the next vector.
                if (io.out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign io.in_ready  = (state_q != HOLD);
    assign io.out_valid = (state_q == HOLD);
    assign io.out_data  = out_data_q;
    assign io.out_sat   = out_sat_q;
    assign busy         = (state_q == ACC) || (state_q == HOLD);
endmodule

// File: doc/sat_accum_neuron.md
SAT_ACCUM_NEURON -- requirements
Module: sat_accum_neuron

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the signed two's-complement width of inputs, bias and result.
REQ-002 The block SHALL have parameter N_IN, default 8, giving the maximum number of input beats per vector (N_IN >= 1).
REQ-003 The block SHALL have parameter ACC_W, default 12, giving the internal accumulator width; ACC_W >= DATA_W + clog2(N_IN+1) is required so that no internal overflow occurs.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port clk: input, 1 bit, rising-edge clock.
REQ-006 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-007 Port bias: input, DATA_W bits, signed bias, sampled on the first accepted beat of a vector.
REQ-008 Port relu_en: input, 1 bit, ReLU mode select, sampled on the final accepted beat.
REQ-009 Port in_valid: input, 1 bit, in_data/in_last are valid.
REQ-010 Port in_ready: output, 1 bit, block accepts a beat this cycle.
REQ-011 Port in_data: input, DATA_W bits, signed operand.
REQ-012 Port in_last: input, 1 bit, marks the final beat of a short vector.
REQ-013 Port out_valid: output, 1 bit, result available.
REQ-014 Port out_ready: input, 1 bit, consumer accepts the result.
REQ-015 Port out_data: output, DATA_W bits, signed saturated result.
REQ-016 Port out_sat: output, 1 bit, out_data was clamped by saturation.
REQ-017 Port busy: output, 1 bit, high in states ACC and HOLD.

Function
REQ-018 A beat SHALL be accepted only when in_valid && in_ready; in_data/in_last SHALL be ignored otherwise.
REQ-019 The FSM SHALL have states IDLE, ACC, HOLD; in_ready = 1 in IDLE and ACC, 0 in HOLD.
REQ-020 In IDLE, an accepted beat SHALL load acc <= sext(bias) + sext(in_data) and cnt <= 1.
REQ-021 In ACC, an accepted beat SHALL set acc <= acc + sext(in_data) and cnt <= cnt + 1.
REQ-022 A beat SHALL be final when in_last = 1 or it is the N_IN-th beat; a final beat SHALL move the FSM to HOLD, including from IDLE; a non-final beat SHALL move/keep it in ACC.
REQ-023 On the final beat, the result SHALL be computed from the updated sum s and registered:
- s > 2^(DATA_W-1)-1 -> max positive, out_sat = 1
- s < -2^(DATA_W-1) -> min negative, out_sat = 1
- otherwise -> s[DATA_W-1:0], out_sat = 0
REQ-024 If relu_en = 1 and the saturated result is negative, out_data SHALL be 0 and out_sat SHALL be 0.
REQ-025 out_valid SHALL rise the cycle after the final beat is accepted (latency 1).
REQ-026 In HOLD, out_valid, out_data and out_sat SHALL remain stable until out_valid && out_ready.
REQ-027 On the output handshake, the FSM SHALL return to IDLE next cycle with out_valid = 0; there is no input/output overlap.
REQ-028 Minimum vector period SHALL be (beats + 1) cycles when out_ready is held high.
REQ-029 out_data and out_sat SHALL retain their last values after out_valid falls; they are only meaningful while out_valid = 1.
REQ-030 cnt SHALL be clog2(N_IN+1) bits wide and SHALL never exceed N_IN.

Reset
REQ-031 rst = 1 SHALL immediately force: state IDLE, acc = 0, cnt = 0, out_valid = 0, out_data = 0, out_sat = 0, busy = 0.
REQ-032 Reset during ACC or HOLD SHALL discard the partial sum or pending result; the first beat after reset release SHALL start a fresh vector.

Verification (DATA_W=8, N_IN=8, ACC_W=12)
REQ-033 Bias 5, 8 beats of 10, out_ready=1 -> out_data=85, out_sat=0, out_valid one cycle after beat 8.
REQ-034 Bias 127, 8 beats of 100 -> out_data=127, out_sat=1; bias -128, 8 beats of -128, relu_en=0 -> out_data=-128, out_sat=1.
REQ-035 Same negative vector with relu_en=1 on the final beat -> out_data=0, out_sat=0.
REQ-036 Bias 0, beats 1,2,3 with in_last on beat 3 -> out_data=6 after 3 beats; the next beat is accepted as a new vector only after the output handshake.
REQ-037 Hold out_ready=0 for 5 cycles after a result -> out_valid=1, out_data stable, in_ready=0, and in_valid pulses are not accepted; out_ready=1 -> IDLE next cycle.
REQ-038 Assert rst after 4 beats of a vector -> all outputs 0 asynchronously; a subsequent bias 0 vector of 8 beats of 1 -> out_data=8.
